// File: rtl/axictrl_pkg.sv
// Shared FSM encoding and AXI constants for the burst copy engine.
package axictrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axsize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/sdpram.sv
// Simple dual-port RAM, one write port and one read port, 1-cycle read latency.
module sdpram #(
  parameter string MEM_STYLE = "block",
  parameter int    DSIZE     = 128,
  parameter int    ASIZE     = 4
) (
  input  logic             i_clk,
  input  logic             i_wen,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_ren,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);
  logic [DSIZE-1:0] r_mem [2**ASIZE];

  always_ff @(posedge i_clk)
    if (i_wen) r_mem[i_waddr] <= i_wdata;

  generate
    if (MEM_STYLE == "distributed") begin : g_dist
      // Register the address and read asynchronously; latency stays one cycle.
      logic [ASIZE-1:0] r_raddr;
      always_ff @(posedge i_clk)
        if (i_ren) r_raddr <= i_raddr;
      assign o_rdata = r_mem[r_raddr];
    end else begin : g_block
      logic [DSIZE-1:0] r_rdata;
      always_ff @(posedge i_clk)
        if (i_ren) r_rdata <= r_mem[i_raddr];
      assign o_rdata = r_rdata;
    end
  endgenerate
endmodule

// File: rtl/axictrl_burst.sv
// Multi-burst DDR-to-DDR copy engine: read a burst into staging RAM, write it back.
// Optional error tracking/abort is enabled with `define AXICTRL_BURST_ERR_EN.
module axictrl_burst #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int BURST_MAX          = 16,
  parameter int ASIZE              = 4
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic                            I_ap_start,
  output logic                            O_ap_done,
  output logic                            O_ap_ready,
  output logic                            O_ap_idle,
  output logic                            O_err,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   I_src_addr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   I_dst_addr,
  input  logic [31:0]                     I_len,
  output logic                            O_maxi_arvalid,
  input  logic                            I_maxi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   O_maxi_araddr,
  output logic [7:0]                      O_maxi_arlen,
  output logic [1:0]                      O_maxi_arburst,
  output logic [2:0]                      O_maxi_arsize,
  output logic [C_M_AXI_ID_WIDTH-1:0]     O_maxi_arid,
  output logic                            O_maxi_aruser,
  output logic                            O_maxi_arlock,
  output logic [3:0]                      O_maxi_arcache,
  output logic [2:0]                      O_maxi_arprot,
  output logic [3:0]                      O_maxi_arqos,
  output logic [3:0]                      O_maxi_arregion,
  input  logic                            I_maxi_rvalid,
  output logic                            O_maxi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   I_maxi_rdata,
  input  logic [1:0]                      I_maxi_rresp,
  input  logic                            I_maxi_rlast,
  output logic                            O_maxi_awvalid,
  input  logic                            I_maxi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   O_maxi_awaddr,
  output logic [7:0]                      O_maxi_awlen,
  output logic [1:0]                      O_maxi_awburst,
  output logic [2:0]                      O_maxi_awsize,
  output logic [C_M_AXI_ID_WIDTH-1:0]     O_maxi_awid,
  output logic                            O_maxi_awuser,
  output logic                            O_maxi_awlock,
  output logic [3:0]                      O_maxi_awcache,
  output logic [2:0]                      O_maxi_awprot,
  output logic [3:0]                      O_maxi_awqos,
  output logic [3:0]                      O_maxi_awregion,
  output logic                            O_maxi_wvalid,
  input  logic                            I_maxi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   O_maxi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] O_maxi_wstrb,
  output logic                            O_maxi_wlast,
  input  logic                            I_maxi_bvalid,
  output logic                            O_maxi_bready,
  input  logic [1:0]                      I_maxi_bresp
);
  import axictrl_pkg::*;

  localparam int         AW     = C_M_AXI_ADDR_WIDTH;
  localparam int         DW     = C_M_AXI_DATA_WIDTH;
  localparam int         SZ     = $clog2(DW / 8);
  localparam logic [8:0] BMAX   = 9'(BURST_MAX);
  localparam logic [2:0] AXSIZE = axsize(DW);

  state_t          r_state, w_next;
  logic [AW-1:0]   r_src, r_dst, w_step;
  logic [31:0]     r_rem, w_rem_nxt, w_len_sel;
  logic [8:0]      r_beats, w_beats_nxt, r_rcnt, r_rd;
  logic [7:0]      r_axlen;
  logic            r_arvalid, r_rready, r_awvalid, r_bready, r_done, r_idle;
  logic            w_arvalid_d, w_rready_d, w_awvalid_d, w_bready_d, w_done_d, w_idle_d;
  logic            w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_start, w_abort;
  logic            r_wvalid, r_wlast, r_sk_v, r_sk_last, r_pend, r_pend_last, w_ren;
  logic [DW-1:0]   r_wdata, r_sk_data, w_ram_q;
  logic [1:0]      w_occ;

  assign w_start   = (r_state == S_IDLE) && I_ap_start;
  assign w_ar_hs   = r_arvalid && I_maxi_arready;
  assign w_r_hs    = I_maxi_rvalid && r_rready;
  assign w_aw_hs   = r_awvalid && I_maxi_awready;
  assign w_w_hs    = r_wvalid && I_maxi_wready;
  assign w_b_hs    = I_maxi_bvalid && r_bready;
  assign w_rem_nxt = r_rem - 32'(r_beats);
  assign w_len_sel = (r_state == S_IDLE) ? I_len : w_rem_nxt;
  assign w_beats_nxt = (w_len_sel >= 32'(BURST_MAX)) ? BMAX : w_len_sel[8:0];
  assign w_step    = AW'(r_beats) << SZ;

`ifdef AXICTRL_BURST_ERR_EN
  logic r_err, w_r_bad;
  assign w_r_bad = (I_maxi_rresp != RESP_OKAY) || (I_maxi_rlast != (r_rcnt == r_beats - 9'd1));
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n)                                                    r_err <= 1'b0;
    else if (w_start)                                                r_err <= 1'b0;
    else if ((w_r_hs && w_r_bad) || (w_b_hs && I_maxi_bresp != RESP_OKAY)) r_err <= 1'b1;
  // Abort only after the current burst's B handshake so the slave sees a clean burst.
  assign w_abort = r_err || (I_maxi_bresp != RESP_OKAY);
  assign O_err   = r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{I_maxi_rresp, I_maxi_bresp, r_rcnt};
  assign w_abort = 1'b0;
  assign O_err   = 1'b0;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (I_ap_start) w_next = (I_len == 32'd0) ? S_DONE : S_AR;
      S_AR:   if (w_ar_hs) w_next = S_R;
      S_R:    if (w_r_hs && I_maxi_rlast) w_next = S_AW;
      S_AW:   if (w_aw_hs) w_next = S_W;
      S_W:    if (w_w_hs && r_wlast) w_next = S_B;
      S_B:    if (w_b_hs) w_next = (w_rem_nxt != 32'd0 && !w_abort) ? S_AR : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state and registered.
  always_comb begin
    w_arvalid_d = (w_next == S_AR);
    w_rready_d  = (w_next == S_R);
    w_awvalid_d = (w_next == S_AW);
    w_bready_d  = (w_next == S_B);
    w_done_d    = (w_next == S_DONE);
    w_idle_d    = (w_next == S_IDLE);
  end

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_arvalid <= 1'b0; r_rready <= 1'b0; r_awvalid <= 1'b0;
      r_bready  <= 1'b0; r_done   <= 1'b0; r_idle    <= 1'b1;
    end else begin
      r_arvalid <= w_arvalid_d; r_rready <= w_rready_d; r_awvalid <= w_awvalid_d;
      r_bready  <= w_bready_d;  r_done   <= w_done_d;   r_idle    <= w_idle_d;
    end

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_src <= '0; r_dst <= '0; r_rem <= '0; r_beats <= '0; r_axlen <= '0;
    end else if (w_start) begin
      r_src   <= I_src_addr;
      r_dst   <= I_dst_addr;
      r_rem   <= I_len;
      r_beats <= w_beats_nxt;
      r_axlen <= 8'(w_beats_nxt - 9'd1);
    end else if (r_state == S_B && w_b_hs) begin
      r_src   <= r_src + w_step;
      r_dst   <= r_dst + w_step;
      r_rem   <= w_rem_nxt;
      r_beats <= w_beats_nxt;
      r_axlen <= 8'(w_beats_nxt - 9'd1);
    end

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n)              r_rcnt <= '0;
    else if (r_state == S_AR)  r_rcnt <= '0;
    else if (w_r_hs)           r_rcnt <= r_rcnt + 9'd1;

  sdpram #(.MEM_STYLE("block"), .DSIZE(DW), .ASIZE(ASIZE)) u_stage (
    .i_clk(I_clk), .i_wen(w_r_hs), .i_waddr(r_rcnt[ASIZE-1:0]), .i_wdata(I_maxi_rdata),
    .i_ren(w_ren), .i_raddr(r_rd[ASIZE-1:0]), .o_rdata(w_ram_q)
  );

  // A RAM read is issued only if the output and skid registers can absorb it,
  // counting the read already in flight.
  assign w_occ = 2'(r_wvalid) + 2'(r_sk_v) + 2'(r_pend) - 2'(w_w_hs);
  assign w_ren = (r_state == S_W) && (r_rd < r_beats) && (w_occ < 2'd2);

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_rd <= '0; r_pend <= 1'b0; r_pend_last <= 1'b0;
    end else begin
      r_rd        <= (r_state != S_W) ? 9'd0 : (w_ren ? r_rd + 9'd1 : r_rd);
      r_pend      <= w_ren;
      r_pend_last <= w_ren && (r_rd == r_beats - 9'd1);
    end

  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_wvalid <= 1'b0; r_wlast <= 1'b0; r_wdata <= '0;
      r_sk_v   <= 1'b0; r_sk_last <= 1'b0; r_sk_data <= '0;
    end else if (!r_wvalid || w_w_hs) begin
      if (r_sk_v) begin
        r_wvalid  <= 1'b1;
        r_wdata   <= r_sk_data;
        r_wlast   <= r_sk_last;
        r_sk_v    <= r_pend;
        r_sk_data <= w_ram_q;
        r_sk_last <= r_pend_last;
      end else if (r_pend) begin
        r_wvalid <= 1'b1;
        r_wdata  <= w_ram_q;
        r_wlast  <= r_pend_last;
      end else begin
        r_wvalid <= 1'b0;
        r_wlast  <= 1'b0;
      end
    end else if (r_pend) begin
      r_sk_v    <= 1'b1;
      r_sk_data <= w_ram_q;
      r_sk_last <= r_pend_last;
    end

  assign O_ap_done  = r_done;
  assign O_ap_ready = r_done;
  assign O_ap_idle  = r_idle;

  assign O_maxi_arvalid  = r_arvalid;
  assign O_maxi_araddr   = r_src;
  assign O_maxi_arlen    = r_axlen;
  assign O_maxi_arburst  = BURST_INCR;
  assign O_maxi_arsize   = AXSIZE;
  assign O_maxi_arid     = '0;
  assign O_maxi_aruser   = 1'b0;
  assign O_maxi_arlock   = 1'b0;
  assign O_maxi_arcache  = 4'd0;
  assign O_maxi_arprot   = 3'd0;
  assign O_maxi_arqos    = 4'd0;
  assign O_maxi_arregion = 4'd0;
  assign O_maxi_rready   = r_rready;

  assign O_maxi_awvalid  = r_awvalid;
  assign O_maxi_awaddr   = r_dst;
  assign O_maxi_awlen    = r_axlen;
  assign O_maxi_awburst  = BURST_INCR;
  assign O_maxi_awsize   = AXSIZE;
  assign O_maxi_awid     = '0;
  assign O_maxi_awuser   = 1'b0;
  assign O_maxi_awlock   = 1'b0;
  assign O_maxi_awcache  = 4'd0;
  assign O_maxi_awprot   = 3'd0;
  assign O_maxi_awqos    = 4'd0;
  assign O_maxi_awregion = 4'd0;

  assign O_maxi_wvalid   = r_wvalid;
  assign O_maxi_wdata    = r_wdata;
  assign O_maxi_wlast    = r_wlast;
  assign O_maxi_wstrb    = '1;
  assign O_maxi_bready   = r_bready;
endmodule

// File: doc/axictrl_burst.md
# axictrl_burst

Parametrised DDR-to-DDR copy engine in the cnna AXI control path. It replaces the single-burst, fixed-width loopback controller with a multi-burst engine. A transfer of I_len beats is split into bursts of at most BURST_MAX beats. Each burst is read over the AXI master read channels into an internal staging RAM, then written back to a separate destination address with correct AXI len, last and strobe encoding. It is started and monitored through the standard ap_start/ap_done/ap_idle/ap_ready handshake from the register block.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 128, AXI data width; power of two, ≥ 32
- C_M_AXI_ID_WIDTH, 1, AXI ID width
- BURST_MAX, 16, maximum beats per burst; power of two, ≤ 256
- ASIZE, 4, staging RAM address width; 2^ASIZE ≥ BURST_MAX
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- I_ap_start  in  1  start request; sampled only in IDLE
- O_ap_done, O_ap_ready  out  1  one-cycle pulse on completion
- O_ap_idle  out  1  high in IDLE
- O_err  out  1  sticky error; cleared on the next accepted start (only with AXICTRL_BURST_ERR_EN)
- I_src_addr, I_dst_addr  in  C_M_AXI_ADDR_WIDTH  byte addresses; aligned to BURST_MAX*DATA_WIDTH/8
- I_len  in  32  total beats
- O_maxi_arvalid/I_maxi_arready/O_maxi_araddr/O_maxi_arlen(8)  AR channel
- I_maxi_rvalid/O_maxi_rready/I_maxi_rdata/I_maxi_rresp(2)/I_maxi_rlast  R channel
- O_maxi_awvalid/I_maxi_awready/O_maxi_awaddr/O_maxi_awlen(8)  AW channel
- O_maxi_wvalid/I_maxi_wready/O_maxi_wdata/O_maxi_wstrb(DATA_WIDTH/8)/O_maxi_wlast  W channel
- I_maxi_bvalid/O_maxi_bready/I_maxi_bresp(2)  B channel
- Constant-driven fields:
  - burst = INCR (2'b01)
  - size = log2(DATA_WIDTH/8)
  - id, user, lock, cache, prot, qos, region = 0

## Operation
- FSM states: IDLE → AR → R → AW → W → B → (AR, or DONE) → IDLE.
- IDLE: I_ap_start=1 latches src, dst and len, and moves to AR.
  - If I_len=0, go straight to DONE with no bus traffic.
- Beats per burst: beats = min(remaining, BURST_MAX). axlen = beats-1.
- AR: arvalid held until arready. araddr = current src pointer.
- R: rready=1. Each accepted beat is written to staging RAM at address 0..beats-1.
  - Exit on the accepted beat with rlast.
  - A beat count mismatch against rlast is an error (ERR_EN builds) or ignored (otherwise).
- AW: awvalid held until awready. awaddr = current dst pointer.
- W: streams RAM words 0..beats-1.
  - wlast asserted on beat beats-1.
  - wstrb is all ones.
- B: bready=1. On bvalid:
  - src and dst advance by beats*DATA_WIDTH/8.
  - remaining decrements by beats.
  - Next state is AR if remaining>0, else DONE.
- DONE: pulses O_ap_done and O_ap_ready for one cycle, then returns to IDLE.
- I_ap_start held high re-triggers from IDLE on the cycle after DONE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; remaining is a 32-bit unsigned value.

## Timing
- Reset values: all valid/ready outputs 0, O_ap_done 0, O_ap_ready 0, O_ap_idle 1, O_err 0. State = IDLE.
- Reset mid-transfer abandons the transaction immediately. No completion of an outstanding burst is attempted.
- Start to arvalid: 1 cycle.
- Staging RAM read latency: 1 cycle. W uses a 2-entry skid register. Full throughput: wready held high gives 1 beat/cycle with no bubbles after the first beat.
- Data must hold while waiting: wdata, wlast and wvalid are stable while wvalid&&!wready.
- All outputs are registered. AXI valids never drop before the handshake.
- Last-beat to B: the B handshake may occur in the cycle after the last W handshake.
- bvalid arriving during W is held off (bready=0) until the B state.

## Configuration
- AXICTRL_BURST_ERR_EN defined:
  - Any rresp≠OKAY, bresp≠OKAY, or rlast beat-count mismatch sets O_err.
  - After the current burst's B handshake the FSM aborts to DONE.
- Undefined:
  - resp inputs are ignored and O_err is tied to 0.
  - rlast is used only to exit R.

## Structure
- Package axictrl_pkg holds:
  - FSM state encoding
  - AXI constants: BURST_INCR, RESP_OKAY
  - axsize computation function
- Sub-module: existing sdpram (MEM_STYLE "block", DSIZE=C_M_AXI_DATA_WIDTH, ASIZE).
- The W-channel skid is inline logic, not a separate module.

## Test plan
- I_len=16, BURST_MAX=16, ready always high -> one AR (arlen=15), 16 R beats, one AW (awlen=15), 16 W beats, wlast on beat 16, ap_done exactly once.
- I_len=40, src=0x1000, dst=0x8000 -> three bursts:
  - araddr = 0x1000, 0x1100, 0x1200; arlen = 15, 15, 7
  - awaddr = 0x8000, 0x8100, 0x8200
  - data matches byte-for-byte.
- Random wready/rvalid/awready/bvalid backpressure, I_len=33 -> wdata stable during stalls; no beat lost or duplicated; wlast at beats 16, 32, 33.
- I_len=0 -> no AXI valids; ap_done one cycle later.
- ERR_EN build, bresp=SLVERR on burst 1 of I_len=48 -> O_err=1; no AR for burst 2; ap_done pulses. A new start clears O_err.
- I_rst_n low during W -> all valids 0 and O_ap_idle=1 asynchronously; a restart with I_len=16 completes correctly.
